// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_pkg;

  // Widest register address any instance may use; narrower addresses are zero-extended.
  localparam int unsigned REG_AW_MAX = 8;

  // Forwarding select value meaning "read the register file".
  localparam int unsigned FWD_REGFILE = 0;

  localparam logic [REG_AW_MAX-1:0] REG_ZERO = '0;

  // One in-flight instruction tracked after ID.
  typedef struct packed {
    logic                  valid;
    logic [REG_AW_MAX-1:0] wreg;
    logic                  reg_write;
    logic                  is_load;
  } slot_t;

  // A slot produces a forwardable result only if it is live and targets a real register.
  function automatic logic slot_writes(input slot_t s);
    return s.valid && s.reg_write && (s.wreg != REG_ZERO);
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Finds the newest scoreboard slot writing one ID source and whether it can forward yet.
module fwd_match
  import pipe_pkg::*;
#(
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned LOAD_READY = 1,
  parameter int unsigned SEL_W      = 2
) (
  input  logic                  used,
  input  logic [REG_AW_MAX-1:0] src,
  input  slot_t [DEPTH-1:0]     slots,
  output logic                  hit,
  output logic                  ready,
  output logic [SEL_W-1:0]      sel
);

  // Scan oldest to newest so the lowest matching slot overwrites and wins.
  always_comb begin
    hit   = 1'b0;
    ready = 1'b0;
    sel   = SEL_W'(FWD_REGFILE);
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (used && (src != REG_ZERO) && slot_writes(slots[k]) && (slots[k].wreg == src)) begin
        hit   = 1'b1;
        ready = !slots[k].is_load || (k >= int'(LOAD_READY));
        sel   = ready ? SEL_W'(k + 1) : SEL_W'(FWD_REGFILE);
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller: scoreboard of in-flight writers, operand forwarding selects,
// load-use / multi-cycle freeze stalls and taken-branch flush.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned LOAD_READY = 1,
  parameter int unsigned CNT_W      = 32,
  localparam int unsigned SEL_W     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic [REG_AW-1:0] id_wreg,
  input  logic              id_reg_write,
  input  logic              id_is_load,
  input  logic              id_branch_taken,
  input  logic              ex_busy,
  output logic              stall_pc,
  output logic              stall_if_id,
  output logic              flush_if_id,
  output logic              bubble_id_ex,
  output logic [SEL_W-1:0]  fwd_sel_a,
  output logic [SEL_W-1:0]  fwd_sel_b,
  output logic [DEPTH-1:0]  pending_mask,
  output logic [CNT_W-1:0]  stall_count
);

  slot_t [DEPTH-1:0] slots_q, slots_d;
  logic  [CNT_W-1:0] stall_count_q;
  slot_t             id_entry;
  logic              hit_a, ready_a, hit_b, ready_b;
  logic              freeze, load_use;

  fwd_match #(
    .DEPTH      (DEPTH),
    .LOAD_READY (LOAD_READY),
    .SEL_W      (SEL_W)
  ) u_match_rs (
    .used  (id_rs_used),
    .src   (REG_AW_MAX'(id_rs)),
    .slots (slots_q),
    .hit   (hit_a),
    .ready (ready_a),
    .sel   (fwd_sel_a)
  );

  fwd_match #(
    .DEPTH      (DEPTH),
    .LOAD_READY (LOAD_READY),
    .SEL_W      (SEL_W)
  ) u_match_rt (
    .used  (id_rt_used),
    .src   (REG_AW_MAX'(id_rt)),
    .slots (slots_q),
    .hit   (hit_b),
    .ready (ready_b),
    .sel   (fwd_sel_b)
  );

  // Hazard priority: freeze over load-use over branch; a suppressed branch retries next cycle.
  always_comb begin
    freeze       = ex_busy;
    load_use     = id_valid && ((hit_a && !ready_a) || (hit_b && !ready_b));
    stall_pc     = freeze || load_use;
    stall_if_id  = stall_pc;
    bubble_id_ex = !freeze && load_use;
    flush_if_id  = !freeze && !load_use && id_valid && id_branch_taken;
  end

  // Next scoreboard: hold on freeze, else shift and insert ID entry (or a bubble on load-use).
  always_comb begin
    id_entry.valid     = id_valid;
    id_entry.wreg      = REG_AW_MAX'(id_wreg);
    id_entry.reg_write = id_reg_write;
    id_entry.is_load   = id_is_load;
    slots_d = slots_q;
    if (!freeze) begin
      slots_d = {slots_q[DEPTH-2:0], (load_use ? slot_t'('0) : id_entry)};
    end
  end

  // Per-slot writer flags for observation.
  always_comb begin
    pending_mask = '0;
    for (int k = 0; k < DEPTH; k++) begin
      pending_mask[k] = slot_writes(slots_q[k]);
    end
  end

  // Scoreboard and saturating stall counter state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slots_q       <= '0;
      stall_count_q <= '0;
    end else begin
      slots_q <= slots_d;
      if (stall_pc && (stall_count_q != {CNT_W{1'b1}})) begin
        stall_count_q <= stall_count_q + 1'b1;
      end
    end
  end

  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (DEPTH=3/LOAD_READY=1 and DEPTH=5/LOAD_READY=3)
// share stimulus; a queue-based model predicts every output each cycle, and directed
// literal checks pin the expected behaviour of the model.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_rs_used, id_rt_used, id_reg_write, id_is_load, id_branch_taken;
  logic       ex_busy;
  logic [4:0] id_rs, id_rt, id_wreg;

  logic        a_spc, a_sif, a_fl, a_bub;
  logic [1:0]  a_sa, a_sb;
  logic [2:0]  a_mask;
  logic [31:0] a_cnt;
  logic        b_spc, b_sif, b_fl, b_bub;
  logic [2:0]  b_sa, b_sb;
  logic [4:0]  b_mask;
  logic [31:0] b_cnt;

  int total = 0;
  int bad   = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.DEPTH(3), .REG_AW(5), .LOAD_READY(1), .CNT_W(32)) u_a (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_wreg(id_wreg),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load), .id_branch_taken(id_branch_taken),
    .ex_busy(ex_busy), .stall_pc(a_spc), .stall_if_id(a_sif), .flush_if_id(a_fl),
    .bubble_id_ex(a_bub), .fwd_sel_a(a_sa), .fwd_sel_b(a_sb), .pending_mask(a_mask),
    .stall_count(a_cnt)
  );

  pipe_hazard_ctrl #(.DEPTH(5), .REG_AW(5), .LOAD_READY(3), .CNT_W(32)) u_b (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_wreg(id_wreg),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load), .id_branch_taken(id_branch_taken),
    .ex_busy(ex_busy), .stall_pc(b_spc), .stall_if_id(b_sif), .flush_if_id(b_fl),
    .bubble_id_ex(b_bub), .fwd_sel_a(b_sa), .fwd_sel_b(b_sb), .pending_mask(b_mask),
    .stall_count(b_cnt)
  );

  // ---------------- model ----------------
  typedef struct {bit v; int w; bit rw; bit ld;} ent_t;
  typedef struct {int spc; int fl; int bub; int sa; int sb; int mask;} exp_t;

  ent_t q3[$];
  ent_t q5[$];
  int   mcnt[2];

  function automatic void reset_model();
    ent_t e;
    e = '{v: 1'b0, w: 0, rw: 1'b0, ld: 1'b0};
    q3.delete();
    q5.delete();
    repeat (3) q3.push_back(e);
    repeat (5) q5.push_back(e);
    mcnt[0] = 0;
    mcnt[1] = 0;
  endfunction

  // Newest in-flight writer of r; forwards from position i as i+1 once the value exists.
  function automatic int fsel(input ent_t q[$], input int lr, input bit used, input int r,
                              output bit notready);
    notready = 1'b0;
    if (!used || r == 0) return 0;
    foreach (q[i]) begin
      if (q[i].v && q[i].rw && q[i].w == r) begin
        if (q[i].ld && i < lr) begin
          notready = 1'b1;
          return 0;
        end
        return i + 1;
      end
    end
    return 0;
  endfunction

  function automatic void predict(input int cfg, output exp_t e, output bit lu);
    ent_t q[$];
    int   lr;
    bit   nra, nrb;
    if (cfg == 0) begin q = q3; lr = 1; end
    else          begin q = q5; lr = 3; end
    e.sa = fsel(q, lr, id_rs_used, int'(id_rs), nra);
    e.sb = fsel(q, lr, id_rt_used, int'(id_rt), nrb);
    lu = id_valid && (nra || nrb);
    e.spc = (ex_busy || lu) ? 1 : 0;
    e.bub = (!ex_busy && lu) ? 1 : 0;
    e.fl  = (!ex_busy && !lu && id_valid && id_branch_taken) ? 1 : 0;
    e.mask = 0;
    foreach (q[i]) if (q[i].v && q[i].rw && q[i].w != 0) e.mask |= (1 << i);
  endfunction

  function automatic void advance(input int cfg);
    exp_t e;
    bit   lu;
    ent_t n;
    predict(cfg, e, lu);
    if (!ex_busy) begin
      if (lu) n = '{v: 1'b0, w: 0, rw: 1'b0, ld: 1'b0};
      else    n = '{v: id_valid, w: int'(id_wreg), rw: id_reg_write, ld: id_is_load};
      if (cfg == 0) begin void'(q3.pop_back()); q3.push_front(n); end
      else          begin void'(q5.pop_back()); q5.push_front(n); end
    end
    if (e.spc != 0 && mcnt[cfg] != 32'hFFFF_FFFF) mcnt[cfg]++;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) reset_model();
    else begin
      advance(0);
      advance(1);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    exp_t e;
    bit   lu;
    if (started) begin
      predict(0, e, lu);
      chk("a.stall_pc", int'(a_spc), e.spc);
      chk("a.stall_if_id", int'(a_sif), e.spc);
      chk("a.flush", int'(a_fl), e.fl);
      chk("a.bubble", int'(a_bub), e.bub);
      chk("a.sel_a", int'(a_sa), e.sa);
      chk("a.sel_b", int'(a_sb), e.sb);
      chk("a.mask", int'(a_mask), e.mask);
      chk("a.count", int'(a_cnt), mcnt[0]);
      predict(1, e, lu);
      chk("b.stall_pc", int'(b_spc), e.spc);
      chk("b.stall_if_id", int'(b_sif), e.spc);
      chk("b.flush", int'(b_fl), e.fl);
      chk("b.bubble", int'(b_bub), e.bub);
      chk("b.sel_a", int'(b_sa), e.sa);
      chk("b.sel_b", int'(b_sb), e.sb);
      chk("b.mask", int'(b_mask), e.mask);
      chk("b.count", int'(b_cnt), mcnt[1]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input bit v, input int rs, input bit rsu, input int rt, input bit rtu,
                       input int wr, input bit rw, input bit ld, input bit br);
    id_valid = v;  id_rs = 5'(rs); id_rs_used = rsu; id_rt = 5'(rt); id_rt_used = rtu;
    id_wreg = 5'(wr); id_reg_write = rw; id_is_load = ld; id_branch_taken = br;
  endtask

  task automatic nop();
    issue(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wait_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic drain();
    nop();
    repeat (6) next_cyc();
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    next_cyc();
    rst = 1'b1;
  endtask

  initial begin
    reset_model();
    rst = 1'b0;
    ex_busy = 1'b0;
    nop();
    started = 1'b1;
    wait_neg();
    chk("rst.mask", int'(a_mask), 0);
    chk("rst.count", int'(a_cnt), 0);
    chk("rst.stall", int'(a_spc), 0);
    chk("rst.sel_a", int'(a_sa), 0);
    chk("rst.bubble", int'(a_bub), 0);
    next_cyc();
    rst = 1'b1;
    next_cyc();

    // ALU writer of r3, consumer in the next cycle then two cycles later.
    issue(1, 0, 0, 0, 0, 3, 1, 0, 0); next_cyc();
    issue(1, 3, 1, 0, 0, 0, 0, 0, 0); wait_neg();
    chk("alu.slot0.sel_a", int'(a_sa), 1);
    chk("alu.slot0.stall", int'(a_spc), 0);
    next_cyc();
    issue(1, 0, 0, 0, 0, 3, 1, 0, 0); next_cyc();
    nop(); next_cyc(); next_cyc();
    issue(1, 3, 1, 0, 0, 0, 0, 0, 0); wait_neg();
    chk("alu.slot2.sel_a", int'(a_sa), 3);
    next_cyc();
    drain();

    // Load r5 then dependent rt=5.
    issue(1, 0, 0, 5, 0, 5, 1, 1, 0); next_cyc();
    issue(1, 0, 0, 5, 1, 0, 0, 0, 0); wait_neg();
    chk("lu.stall", int'(a_spc), 1);
    chk("lu.bubble", int'(a_bub), 1);
    chk("lu.sel_b", int'(a_sb), 0);
    next_cyc(); wait_neg();
    chk("lu.after.sel_b", int'(a_sb), 2);
    chk("lu.after.stall", int'(a_spc), 0);
    chk("lu.after.count", int'(a_cnt), 1);
    next_cyc();
    drain();

    // Newest writer wins; r0 never forwards.
    issue(1, 0, 0, 0, 0, 7, 1, 0, 0); next_cyc(); next_cyc();
    issue(1, 7, 1, 0, 0, 0, 0, 0, 0); wait_neg();
    chk("newest.sel_a", int'(a_sa), 1);
    next_cyc();
    issue(1, 0, 0, 0, 0, 0, 1, 1, 0); next_cyc();
    issue(1, 0, 0, 0, 1, 0, 0, 0, 0); wait_neg();
    chk("r0.sel_b", int'(a_sb), 0);
    chk("r0.stall", int'(a_spc), 0);
    chk("r0.b.stall", int'(b_spc), 0);
    next_cyc();
    drain();

    // Four-cycle freeze from a fresh reset.
    pulse_reset();
    issue(1, 0, 0, 0, 0, 9, 1, 0, 0); next_cyc();
    issue(1, 0, 0, 0, 0, 10, 1, 0, 0); next_cyc();
    issue(1, 9, 1, 0, 0, 0, 0, 0, 0);
    ex_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_neg();
      chk("frz.stall", int'(a_spc), 1);
      chk("frz.bubble", int'(a_bub), 0);
      chk("frz.mask", int'(a_mask), 3);
      chk("frz.sel_a", int'(a_sa), 2);
      next_cyc();
    end
    ex_busy = 1'b0;
    wait_neg();
    chk("frz.count", int'(a_cnt), 4);
    chk("frz.release", int'(a_spc), 0);
    next_cyc();
    drain();

    // Taken branch coinciding with load-use.
    issue(1, 0, 0, 0, 0, 6, 1, 1, 0); next_cyc();
    issue(1, 0, 0, 6, 1, 0, 0, 0, 1); wait_neg();
    chk("br.stall_cycle.flush", int'(a_fl), 0);
    chk("br.stall_cycle.stall", int'(a_spc), 1);
    next_cyc(); wait_neg();
    chk("br.next.flush", int'(a_fl), 1);
    chk("br.next.stall", int'(a_spc), 0);
    next_cyc();
    drain();

    // Stall length LOAD_READY - k: 1 for DEPTH3/LR1, 3 for DEPTH5/LR3.
    pulse_reset();
    issue(1, 0, 0, 0, 0, 4, 1, 1, 0); next_cyc();
    issue(1, 4, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      wait_neg();
      chk("len.a.stall", int'(a_spc), (i < 1) ? 1 : 0);
      chk("len.b.stall", int'(b_spc), (i < 3) ? 1 : 0);
      next_cyc();
    end
    drain();

    // Reset asserted mid-stall.
    issue(1, 0, 0, 0, 0, 4, 1, 1, 0); next_cyc();
    issue(1, 4, 1, 0, 0, 0, 0, 0, 0); wait_neg();
    chk("mid.stall", int'(a_spc), 1);
    rst = 1'b0;
    #1;
    chk("mid.a.mask", int'(a_mask), 0);
    chk("mid.a.count", int'(a_cnt), 0);
    chk("mid.b.mask", int'(b_mask), 0);
    chk("mid.b.count", int'(b_cnt), 0);
    nop();
    #1;
    chk("mid.idle.stall", int'(a_spc), 0);
    chk("mid.idle.bubble", int'(a_bub), 0);
    chk("mid.idle.sel_a", int'(a_sa), 0);
    next_cyc();
    rst = 1'b1;
    wait_neg();
    chk("mid.rel.bubble", int'(a_bub), 0);
    chk("mid.rel.mask", int'(a_mask), 0);
    next_cyc();

    started = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
